reg_bank_n: RTL and testbench

Parametrised successor to the processor's fixed register unit. It holds PC, AC, DR and AR plus NUM_GPR general registers behind one C-bus write port, per-register increment, and a registered B-bus read mux. It adds asynchronous reset, a request/valid handshake for loading DR from RAM, and an instruction register. It sits between the control unit, ALU and RAM in the datapath.

---
 rtl/reg_bank_pkg.sv | 19 +
 rtl/reg_bank_n_cell.sv | 52 +++++
 rtl/reg_bank_n.sv | 142 ++++++++++++++
 tb/tb_reg_bank_n.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the parametrised register bank: register index map,
// DR-load FSM states and the default per-register incrementer mask.
package reg_bank_pkg;

    localparam int IDX_PC   = 0;
    localparam int IDX_AC   = 1;
    localparam int IDX_DR   = 2;
    localparam int IDX_AR   = 3;
    localparam int IDX_GPR0 = 4;

    // PC, AC and GPR0-2 carry incrementers by default.
    localparam int DEFAULT_INC_MASK = 'h73;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } dr_state_e;

endpackage

// File: rtl/reg_bank_n_cell.sv
// One bank register: async reset, write port, optional load port and optional
// wrapping increment/decrement. Priority: write > load > (inc xor dec) > hold.
module reg_cell #(
    parameter int DATA_LEN = 16,
    parameter bit HAS_INC  = 1'b0,
    parameter bit HAS_LOAD = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [DATA_LEN-1:0] wdata_i,
    input  logic                load_i,
    input  logic [DATA_LEN-1:0] ldata_i,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [DATA_LEN-1:0] q_o
);

    logic [DATA_LEN-1:0] val_q;
    logic [DATA_LEN-1:0] val_d;
    logic                load_en;
    logic                inc_en;
    logic                dec_en;

    always_comb begin
        load_en = HAS_LOAD && load_i;
        // Simultaneous inc and dec cancel out and the register holds.
        inc_en  = HAS_INC && inc_i && !dec_i;
        dec_en  = HAS_INC && dec_i && !inc_i;
        val_d   = val_q;
        if (we_i) begin
            val_d = wdata_i;
        end else if (load_en) begin
            val_d = ldata_i;
        end else if (inc_en) begin
            val_d = val_q + DATA_LEN'(1);
        end else if (dec_en) begin
            val_d = val_q - DATA_LEN'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q_o = val_q;

endmodule

// File: rtl/reg_bank_n.sv
// Parametrised register bank: PC/AC/DR/AR + NUM_GPR GPRs, C-bus write, registered
// B-bus mux, IR and DR-from-RAM handshake. Define REG_BANK_DEC_EN to add a dec port.
module reg_bank_n
    import reg_bank_pkg::*;
#(
    parameter int DATA_LEN        = 16,
    parameter int ADDRESS_LEN     = 8,
    parameter int INSTRUCTION_LEN = 6,
    parameter int NUM_GPR         = 8,
    localparam int NUM_REGS       = NUM_GPR + 4,
    parameter logic [NUM_REGS-1:0] INC_MASK = NUM_REGS'(DEFAULT_INC_MASK),
    localparam int SEL_LEN        = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_LEN-1:0]        c_bus_in,
    input  logic [NUM_REGS-1:0]        c_we,
    input  logic [NUM_REGS-1:0]        inc,
`ifdef REG_BANK_DEC_EN
    input  logic [NUM_REGS-1:0]        dec,
`endif
    input  logic [SEL_LEN-1:0]         select,
    input  logic                       read_start,
    input  logic [DATA_LEN-1:0]        ram_out,
    input  logic                       mem_rd_valid,
    input  logic                       ir_load,
    output logic                       mem_rd_req,
    output logic [ADDRESS_LEN-1:0]     ram_addr,
    output logic [DATA_LEN-1:0]        ram_in,
    output logic [INSTRUCTION_LEN-1:0] opcode,
    output logic [DATA_LEN-1:0]        ac_out,
    output logic                       ac_zero,
    output logic [DATA_LEN-1:0]        mux_out,
    output logic                       busy
);

    logic [DATA_LEN-1:0]        regs [NUM_REGS];
    logic [NUM_REGS-1:0]        dec_bits;
    logic                       dr_load;
    logic [DATA_LEN-1:0]        mux_d;
    logic [DATA_LEN-1:0]        mux_q;
    logic [INSTRUCTION_LEN-1:0] ir_d;
    logic [INSTRUCTION_LEN-1:0] ir_q;
    dr_state_e                  state_q;
    logic                       req_q;
    logic                       busy_q;

`ifdef REG_BANK_DEC_EN
    assign dec_bits = dec;
`else
    assign dec_bits = '0;
`endif

    // RAM data lands in DR only while a read is outstanding; a C-bus write to
    // DR in the same cycle wins inside the cell and the RAM word is dropped.
    assign dr_load = (state_q == WAIT) && mem_rd_valid;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        reg_cell #(
            .DATA_LEN (DATA_LEN),
            .HAS_INC  (INC_MASK[i]),
            .HAS_LOAD (i == IDX_DR)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .we_i    (c_we[i]),
            .wdata_i (c_bus_in),
            .load_i  (dr_load),
            .ldata_i (ram_out),
            .inc_i   (inc[i]),
            .dec_i   (dec_bits[i]),
            .q_o     (regs[i])
        );
    end

    // Out-of-range select indices fall through to zero.
    always_comb begin
        mux_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (select == SEL_LEN'(i)) begin
                mux_d = regs[i];
            end
        end
    end

    always_comb begin
        ir_d = ir_q;
        if (ir_load) begin
            ir_d = regs[IDX_DR][INSTRUCTION_LEN-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mux_q <= '0;
            ir_q  <= '0;
        end else begin
            mux_q <= mux_d;
            ir_q  <= ir_d;
        end
    end

    // DR load handshake: one-cycle request on entry to WAIT, busy until data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            req_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (read_start) begin
                        state_q <= WAIT;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_rd_valid) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd_req = req_q;
    assign busy       = busy_q;
    assign ram_addr   = regs[IDX_AR][ADDRESS_LEN-1:0];
    assign ram_in     = regs[IDX_DR];
    assign opcode     = ir_q;
    assign ac_out     = regs[IDX_AC];
    assign ac_zero    = (regs[IDX_AC] == '0);
    assign mux_out    = mux_q;

endmodule

// File: tb/tb_reg_bank_n.sv
// Self-checking bench for reg_bank_n: vector table, directed corner sequences
// and randomized traffic against an array-based reference model.
module tb_reg_bank_n;

    localparam logic [11:0] MASK = 12'h073;

    logic        clk;
    logic        rst;
    logic [15:0] c_bus_in;
    logic [11:0] c_we;
    logic [11:0] inc;
    logic [11:0] dec_v;
    logic [3:0]  select;
    logic        read_start;
    logic [15:0] ram_out;
    logic        mem_rd_valid;
    logic        ir_load;
    logic        mem_rd_req;
    logic [7:0]  ram_addr;
    logic [15:0] ram_in;
    logic [5:0]  opcode;
    logic [15:0] ac_out;
    logic        ac_zero;
    logic [15:0] mux_out;
    logic        busy;

    int tests = 0;
    int fails = 0;

    reg_bank_n dut (
        .clk          (clk),
        .rst          (rst),
        .c_bus_in     (c_bus_in),
        .c_we         (c_we),
        .inc          (inc),
`ifdef REG_BANK_DEC_EN
        .dec          (dec_v),
`endif
        .select       (select),
        .read_start   (read_start),
        .ram_out      (ram_out),
        .mem_rd_valid (mem_rd_valid),
        .ir_load      (ir_load),
        .mem_rd_req   (mem_rd_req),
        .ram_addr     (ram_addr),
        .ram_in       (ram_in),
        .opcode       (opcode),
        .ac_out       (ac_out),
        .ac_zero      (ac_zero),
        .mux_out      (mux_out),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    logic [15:0] m_reg [12];
    logic [15:0] m_mux;
    logic [5:0]  m_ir;
    bit          m_wait;
    bit          m_req;

    task automatic model_reset();
        for (int i = 0; i < 12; i++) m_reg[i] = 16'h0;
        m_mux  = 16'h0;
        m_ir   = 6'h0;
        m_wait = 1'b0;
        m_req  = 1'b0;
    endtask

    task automatic model_step();
        logic [15:0] nxt [12];
        bit ld;
        int delta;
        ld = m_wait && mem_rd_valid;
        for (int i = 0; i < 12; i++) begin
            delta = 0;
            if (MASK[i]) delta = int'(inc[i]) - int'(dec_v[i]);
            if (c_we[i]) nxt[i] = c_bus_in;
            else if (i == 2 && ld) nxt[i] = ram_out;
            else nxt[i] = 16'(int'(m_reg[i]) + delta);
        end
        m_mux = (int'(select) < 12) ? m_reg[select] : 16'h0;
        if (ir_load) m_ir = m_reg[2][5:0];
        m_req = !m_wait && read_start;
        if (!m_wait && read_start) m_wait = 1'b1;
        else if (m_wait && mem_rd_valid) m_wait = 1'b0;
        for (int i = 0; i < 12; i++) m_reg[i] = nxt[i];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".mux_out"},    32'(mux_out),    32'(m_mux));
        chk({tag, ".opcode"},     32'(opcode),     32'(m_ir));
        chk({tag, ".mem_rd_req"}, 32'(mem_rd_req), 32'(m_req));
        chk({tag, ".busy"},       32'(busy),       32'(m_wait));
        chk({tag, ".ram_in"},     32'(ram_in),     32'(m_reg[2]));
        chk({tag, ".ram_addr"},   32'(ram_addr),   32'(m_reg[3][7:0]));
        chk({tag, ".ac_out"},     32'(ac_out),     32'(m_reg[1]));
        chk({tag, ".ac_zero"},    32'(ac_zero),    32'(m_reg[1] == 16'h0));
    endtask

    task automatic idle_inputs();
        c_bus_in     = 16'h0;
        c_we         = 12'h0;
        inc          = 12'h0;
        dec_v        = 12'h0;
        select       = 4'h0;
        read_start   = 1'b0;
        ram_out      = 16'h0;
        mem_rd_valid = 1'b0;
        ir_load      = 1'b0;
    endtask

    task automatic tick(input string tag);
        if ($countones(c_we) > 1) $display("[TB] protocol error: several c_we bits set %b", c_we);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Reset asserted between edges: outputs must clear without a clock.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, ".ac_zero_async"}, 32'(ac_zero), 32'h1);
        chk({tag, ".busy_async"},    32'(busy),    32'h0);
        #2 rst = 1'b0;
    endtask

    typedef struct {
        int          idx;
        logic [15:0] wval;
        bit          do_inc;
        logic [3:0]  sel;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{4,  16'hBEEF, 1'b0, 4'd4,  16'hBEEF};
        vecs[1] = '{0,  16'hFFFF, 1'b1, 4'd0,  16'h0000};
        vecs[2] = '{2,  16'h0042, 1'b1, 4'd2,  16'h0042};
        vecs[3] = '{5,  16'h7FFF, 1'b1, 4'd5,  16'h8000};
        vecs[4] = '{7,  16'h1234, 1'b1, 4'd7,  16'h1234};
        vecs[5] = '{6,  16'h0001, 1'b1, 4'd6,  16'h0002};
        vecs[6] = '{11, 16'hCAFE, 1'b0, 4'd15, 16'h0000};
        vecs[7] = '{3,  16'h00AB, 1'b1, 4'd3,  16'h00AB};

        idle_inputs();
        rst = 1'b1;
        model_reset();
        #2;
        check_all("por");
        #10 rst = 1'b0;

        // Vector table: write, optional increment, then read back via B-bus.
        for (int k = 0; k < 8; k++) begin
            idle_inputs();
            c_we[vecs[k].idx] = 1'b1;
            c_bus_in = vecs[k].wval;
            tick("vec_wr");
            idle_inputs();
            inc[vecs[k].idx] = vecs[k].do_inc;
            tick("vec_inc");
            idle_inputs();
            select = vecs[k].sel;
            tick("vec_rd");
            chk("vec_mux", 32'(mux_out), 32'(vecs[k].exp));
        end
        chk("ram_addr_ar", 32'(ram_addr), 32'h00AB);

        // Write beats increment on the same register.
        idle_inputs();
        c_we[1] = 1'b1; c_bus_in = 16'h0005; inc[1] = 1'b1;
        tick("ac_wr_inc");
        chk("ac_write_over_inc", 32'(ac_out), 32'h0005);

`ifdef REG_BANK_DEC_EN
        idle_inputs();
        c_we[1] = 1'b1; c_bus_in = 16'h0000;
        tick("ac_clr");
        chk("ac_zero_after_clr", 32'(ac_zero), 32'h1);
        idle_inputs();
        dec_v[1] = 1'b1;
        tick("ac_dec");
        chk("ac_dec_wrap", 32'(ac_out), 32'hFFFF);
        chk("ac_zero_after_dec", 32'(ac_zero), 32'h0);
        idle_inputs();
        inc[1] = 1'b1; dec_v[1] = 1'b1;
        tick("ac_incdec");
        chk("ac_incdec_hold", 32'(ac_out), 32'hFFFF);
`endif

        // RAM load with a repeated read_start while waiting.
        idle_inputs();
        read_start = 1'b1;
        tick("rd_start");
        chk("rd_req_pulse", 32'(mem_rd_req), 32'h1);
        chk("rd_busy", 32'(busy), 32'h1);
        tick("rd_restart");
        chk("rd_no_extra_req", 32'(mem_rd_req), 32'h0);
        idle_inputs();
        tick("rd_wait");
        mem_rd_valid = 1'b1; ram_out = 16'h00A7;
        tick("rd_valid");
        chk("rd_dr", 32'(ram_in), 32'h00A7);
        chk("rd_busy_clear", 32'(busy), 32'h0);

        // Write/load collision on DR, then IR load.
        idle_inputs();
        read_start = 1'b1;
        tick("col_start");
        idle_inputs();
        tick("col_wait");
        c_we[2] = 1'b1; c_bus_in = 16'h1111; mem_rd_valid = 1'b1; ram_out = 16'h2222;
        tick("col_hit");
        chk("col_dr_write_wins", 32'(ram_in), 32'h1111);
        chk("col_busy_clear", 32'(busy), 32'h0);
        idle_inputs();
        mem_rd_valid = 1'b1; ram_out = 16'h3333;
        tick("col_idle_valid");
        chk("idle_valid_ignored", 32'(ram_in), 32'h1111);
        idle_inputs();
        ir_load = 1'b1;
        tick("ir_load");
        chk("ir_opcode", 32'(opcode), 32'h11);
        idle_inputs();
        read_start = 1'b1;
        tick("col_back_idle");
        chk("col_fsm_idle_req", 32'(mem_rd_req), 32'h1);
        idle_inputs();
        mem_rd_valid = 1'b1; ram_out = 16'h0F0F;
        tick("col_finish");

        // Reset in the middle of a pending read.
        idle_inputs();
        c_we[4] = 1'b1; c_bus_in = 16'h1234;
        tick("rst_gpr");
        idle_inputs();
        c_we[1] = 1'b1; c_bus_in = 16'h0009;
        tick("rst_ac");
        idle_inputs();
        select = 4'd4; read_start = 1'b1;
        tick("rst_pend");
        chk("rst_pre_mux", 32'(mux_out), 32'h1234);
        idle_inputs();
        async_reset("rst_mid");
        select = 4'd4;
        tick("rst_gpr_rd");
        chk("rst_gpr0_zero", 32'(mux_out), 32'h0);
        idle_inputs();
        mem_rd_valid = 1'b1; ram_out = 16'h5555;
        tick("rst_late_valid");
        chk("rst_late_valid_ignored", 32'(ram_in), 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            if ($urandom_range(1, 0) == 1) c_we[$urandom_range(11, 0)] = 1'b1;
            c_bus_in     = 16'($urandom);
            if ($urandom_range(7, 0) == 0) c_bus_in = 16'hFFFF;
            inc          = 12'($urandom);
`ifdef REG_BANK_DEC_EN
            dec_v        = 12'($urandom);
`endif
            select       = 4'($urandom);
            read_start   = ($urandom_range(3, 0) == 0);
            mem_rd_valid = ($urandom_range(2, 0) == 0);
            ram_out      = 16'($urandom);
            ir_load      = ($urandom_range(3, 0) == 0);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
